// File: rtl/lms_train_ctrl.sv
// Training sequencer for the 8-element DRCpLMS beamformer: clears the weights, waits for the
// pipeline to fill, gates adaptation per snapshot and latches the weights when the run ends.
module lms_train_ctrl #(
   parameter int unsigned PIPE_LAT = 4,
   parameter int unsigned CLR_CYC  = 2,
   parameter int unsigned MAX_ITER = 1024,
   parameter int unsigned CONV_RUN = 16,
   parameter int unsigned EW       = 18
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic                 abort,
   input  logic                 snap_valid,
   input  logic [EW:0]          err_thr,
   input  logic signed [EW-1:0] econj_i,
   input  logic signed [EW-1:0] econj_q,
   output logic                 clr_w,
   output logic                 adapt_en,
   output logic                 busy,
   output logic                 converged,
   output logic                 done,
   output logic                 w_latch,
   output logic [15:0]          iter_cnt
);

   typedef enum logic [2:0] {StIdle, StInit, StFill, StTrain, StHold} state_e;

   state_e              state_q, state_d;
   logic [7:0]          cnt_q, cnt_d;
   logic [7:0]          run_q, run_d;
   logic [15:0]         iter_q, iter_d;
   logic                conv_q, conv_d;
   logic [PIPE_LAT-1:0] dl_q, dl_d;
   logic                clr_q, busy_q, done_q;
   logic                start_go;
   logic [EW:0]         mag;

   // |x| clamped so the most-negative code cannot wrap to a small magnitude.
   function automatic logic [EW-2:0] sat_abs(input logic [EW-1:0] x);
      logic [EW-1:0] neg;
      neg = -x;
      if (x[EW-1] && (x[EW-2:0] == '0)) return '1;
      else if (x[EW-1]) return neg[EW-2:0];
      else return x[EW-2:0];
   endfunction

   assign mag      = {2'b00, sat_abs(econj_i)} + {2'b00, sat_abs(econj_q)};
   assign adapt_en = dl_q[PIPE_LAT-1] & (state_q == StTrain);

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      run_d    = run_q;
      iter_d   = iter_q;
      conv_d   = conv_q;
      start_go = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d  = StInit;
               start_go = 1'b1;
               cnt_d    = '0;
               run_d    = '0;
               iter_d   = '0;
               conv_d   = 1'b0;
            end
         end
         StInit: begin
            if (abort) begin
               state_d = StHold;
            end else if (cnt_q == 8'(CLR_CYC - 1)) begin
               state_d = StFill;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         StFill: begin
            if (abort) begin
               state_d = StHold;
            end else if (cnt_q == 8'(PIPE_LAT - 1)) begin
               state_d = StTrain;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         StTrain: begin
            if (adapt_en) begin
               iter_d = iter_q + 16'd1;
               if (mag < err_thr) run_d = (run_q == 8'(CONV_RUN)) ? run_q : run_q + 8'd1;
               else               run_d = '0;
            end
            if (abort) begin
               state_d = StHold;
            end else if (adapt_en && (run_d == 8'(CONV_RUN))) begin
               state_d = StHold;
               conv_d  = 1'b1;
            end else if (adapt_en && (iter_d == 16'(MAX_ITER))) begin
               state_d = StHold;
            end
         end
         StHold:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Snapshot-valid delay line; restarted on every new run so stale snapshots never adapt.
   always_comb begin
      dl_d = '0;
      if (!start_go) begin
         dl_d[0] = snap_valid;
         for (int i = 1; i < int'(PIPE_LAT); i++) dl_d[i] = dl_q[i-1];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         run_q   <= '0;
         iter_q  <= '0;
         conv_q  <= 1'b0;
         dl_q    <= '0;
         clr_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         run_q   <= run_d;
         iter_q  <= iter_d;
         conv_q  <= conv_d;
         dl_q    <= dl_d;
         clr_q   <= (state_d == StInit);
         busy_q  <= (state_d inside {StInit, StFill, StTrain});
         done_q  <= (state_d == StHold);
      end
   end

   assign clr_w     = clr_q;
   assign busy      = busy_q;
   assign converged = conv_q;
   assign done      = done_q;
   assign w_latch   = done_q;
   assign iter_cnt  = iter_q;

endmodule

// File: tb/tb_lms_train_ctrl.sv
// Directed bench for lms_train_ctrl at default parameters: table of training runs plus
// hand-written abort and mid-run reset sequences.
module tb_lms_train_ctrl;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               start = 1'b0;
   logic               abort = 1'b0;
   logic               snap_valid = 1'b0;
   logic [18:0]        err_thr = '0;
   logic signed [17:0] econj_i = '0;
   logic signed [17:0] econj_q = '0;
   logic               clr_w, adapt_en, busy, converged, done, w_latch;
   logic [15:0]        iter_cnt;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   lms_train_ctrl dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .abort      (abort),
      .snap_valid (snap_valid),
      .err_thr    (err_thr),
      .econj_i    (econj_i),
      .econj_q    (econj_q),
      .clr_w      (clr_w),
      .adapt_en   (adapt_en),
      .busy       (busy),
      .converged  (converged),
      .done       (done),
      .w_latch    (w_latch),
      .iter_cnt   (iter_cnt)
   );

   typedef struct {
      string name;
      int    gi, gq, bi, bq, thr, period, bad_idx;
      bit    conv;
      int    iter;
      int    done_cyc;
   } vec_t;

   vec_t tbl[8];

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic int sabs(input int v);
      int a;
      a = (v < 0) ? -v : v;
      return (a > 131071) ? 131071 : a;
   endfunction

   function automatic longint outs();
      return {clr_w, adapt_en, busy, converged, done, w_latch, iter_cnt};
   endfunction

   // Cycle 0 is the cycle in which start is high; the model predicts adapt_en per cycle.
   task automatic do_run(input vec_t v);
      int     m_iter, m_run, exit_cyc, seq_err, done_seen, ndone, mag, cur_i, cur_q, cap_iter;
      bit     m_exit, exp_adapt, cap_conv;
      m_iter = 0; m_run = 0; exit_cyc = -10; seq_err = 0; done_seen = -1; ndone = 0;
      m_exit = 0; cap_iter = -1; cap_conv = 0;
      err_thr = 19'(v.thr);
      for (int c = 0; c < 1200; c++) begin
         if (c > 0) step();
         // start while busy (cycle 10) and in HOLD must both be ignored
         start      = (c == 0) || (c == 10) || (c == exit_cyc + 1);
         snap_valid = (c % v.period == 0);
         exp_adapt  = (c >= 7) && !m_exit && ((c - 4) % v.period == 0);
         if (exp_adapt && (m_iter + 1 == v.bad_idx)) begin
            cur_i = v.bi; cur_q = v.bq;
         end else if (exp_adapt) begin
            cur_i = v.gi; cur_q = v.gq;
         end else begin
            cur_i = -131072; cur_q = -131072;
         end
         econj_i = 18'(cur_i);
         econj_q = 18'(cur_q);
         if (clr_w !== ((c == 1) || (c == 2))) seq_err++;
         if (adapt_en !== exp_adapt) seq_err++;
         if (busy !== ((c >= 1) && !m_exit)) seq_err++;
         if (w_latch !== done) seq_err++;
         if (done === 1'b1) begin
            ndone++;
            done_seen = c;
            cap_conv  = converged;
            cap_iter  = iter_cnt;
         end
         if (exp_adapt) begin
            m_iter++;
            mag   = sabs(cur_i) + sabs(cur_q);
            m_run = (mag < v.thr) ? m_run + 1 : 0;
            if ((m_run == 16) || (m_iter == 1024)) begin
               m_exit   = 1;
               exit_cyc = c;
            end
         end
         if (m_exit && (c == exit_cyc + 2)) begin
            start = 1'b0;
            check({v.name, ".iter_hold"}, iter_cnt, v.iter);
            break;
         end
      end
      start = 1'b0;
      check({v.name, ".seq"}, seq_err, 0);
      check({v.name, ".done_cyc"}, done_seen, v.done_cyc);
      check({v.name, ".done_cnt"}, ndone, 1);
      check({v.name, ".conv"}, cap_conv, v.conv);
      check({v.name, ".iter"}, cap_iter, v.iter);
   endtask

   initial begin
      tbl[0] = '{"conv",     10, -20,  0,   0,   100,    1, 0,  1, 16,   23};
      tbl[1] = '{"limit",    -131072, 0, 0, 0,   200,    1, 0,  0, 1024, 1031};
      tbl[2] = '{"sparse",   10, -20,  0,   0,   100,    3, 0,  1, 16,   53};
      tbl[3] = '{"runreset", 10, -20,  60,  -40, 100,    1, 16, 1, 32,   39};
      tbl[4] = '{"thr0",     0,  0,    0,   0,   0,      1, 0,  0, 1024, 1031};
      tbl[5] = '{"edge99",   60, -39,  0,   0,   100,    1, 0,  1, 16,   23};
      tbl[6] = '{"bothneg",  -131072, -131072, 0, 0, 524287, 1, 0, 1, 16, 23};
      tbl[7] = '{"satmax",   131071, 131071, 0, 0, 262142, 1, 0, 0, 1024, 1031};

      // Reset behaviour with snap_valid high and no start
      snap_valid = 1'b1;
      repeat (3) step();
      check("reset.asserted", outs(), 0);
      rst_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         step();
         check("reset.idle", outs(), 0);
      end

      foreach (tbl[i]) begin
         do_run(tbl[i]);
         step();
      end

      // abort in FILL: converged and iter_cnt from the previous run must clear
      err_thr = 19'd100; econj_i = 18'sd10; econj_q = -18'sd20; snap_valid = 1'b1;
      start = 1'b1; step(); start = 1'b0;
      step(); step();
      abort = 1'b1; step(); abort = 1'b0;
      check("abort_fill.done", {done, w_latch}, 2'b11);
      check("abort_fill.conv", converged, 0);
      check("abort_fill.iter", iter_cnt, 0);
      check("abort_fill.busy_clr", {busy, clr_w, adapt_en}, 3'b000);
      step();
      check("abort_fill.after", {done, busy}, 2'b00);

      // abort in INIT: clr_w drops as HOLD is entered
      start = 1'b1; step(); start = 1'b0;
      check("abort_init.clr", clr_w, 1);
      abort = 1'b1; step(); abort = 1'b0;
      check("abort_init.hold", {clr_w, done, w_latch, busy}, 4'b0110);
      step();

      // abort in TRAIN: final update in the abort cycle still counts
      start = 1'b1; step(); start = 1'b0;
      for (int c = 1; c < 12; c++) step();
      check("abort_train.adapt", adapt_en, 1);
      abort = 1'b1; step(); abort = 1'b0;
      check("abort_train.done", {done, converged}, 2'b10);
      check("abort_train.iter", iter_cnt, 6);
      step();

      // asynchronous reset in TRAIN: no done pulse, clean restart afterwards
      start = 1'b1; step(); start = 1'b0;
      for (int c = 1; c < 10; c++) step();
      check("rst_train.busy_before", busy, 1);
      #2 rst_n = 1'b0;
      #1 check("rst_train.outs", outs(), 0);
      for (int i = 0; i < 3; i++) begin
         step();
         check("rst_train.no_done", outs(), 0);
      end
      #2 rst_n = 1'b1;
      step();
      do_run(tbl[0]);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

endmodule

// File: doc/lms_train_ctrl.md
Name: lms_train_ctrl

Overview:
Training sequencer for the 8-element DRCpLMS adaptive beamformer. It clears the weight registers, waits for the combiner/error/update pipeline to fill, and then gates weight adaptation per valid snapshot. Training stops on convergence (error magnitude below a threshold for a run of snapshots), on an iteration limit, or on abort. It then freezes the weights and pulses a latch strobe so the downstream beam-steering logic captures wo1..wo8.

Parameters:
PIPE_LAT, 4, cycles from snapshot accepted to matching econj valid (combiner + error + register stages)
CLR_CYC, 2, cycles clr_w is held asserted in INIT
MAX_ITER, 1024, snapshot limit for one training run (1..65535)
CONV_RUN, 16, consecutive below-threshold error samples required to declare convergence (1..255)
EW, 18, width of each error component

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse: begin a training run
abort  in  1  level: terminate the run and freeze the weights
snap_valid  in  1  a new xin/din snapshot is present this cycle
err_thr  in  EW+1  unsigned convergence threshold on |eI|+|eQ|
econj_i  in  EW  signed error, I component (econjI)
econj_q  in  EW  signed error, Q component (econjQ)
clr_w  out  1  forces the weight registers to zero
adapt_en  out  1  weight-update enable for this cycle
busy  out  1  high in INIT, FILL and TRAIN
converged  out  1  sticky flag: the last run ended by convergence
done  out  1  one-cycle pulse when a run ends
w_latch  out  1  one-cycle pulse, same cycle as done
iter_cnt  out  16  number of snapshots adapted in the current or last run

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; clr_w, adapt_en, busy, converged, done, w_latch = 0; iter_cnt = 0; all internal counters = 0.
- States: IDLE, INIT, FILL, TRAIN, HOLD.
- IDLE:
  - start=1 -> INIT.
  - On that transition: iter_cnt:=0, converged:=0, run counter:=0.
- INIT:
  - clr_w=1 for exactly CLR_CYC cycles, then -> FILL.
  - adapt_en=0 throughout.
- FILL:
  - adapt_en=0.
  - Counts PIPE_LAT cycles, starting at entry and independent of snap_valid, then -> TRAIN.
- TRAIN:
  - adapt_en is the registered snap_valid delayed by PIPE_LAT, so each update lines up with the error for its own snapshot.
  - Delay line: a PIPE_LAT-deep shift register of snap_valid, cleared on entry to INIT.
  - Each cycle with adapt_en=1:
    - iter_cnt increments.
    - mag = sat(|econj_i|) + sat(|econj_q|), computed as an EW+1-bit unsigned sum.
    - sat(|x|) maps the most-negative value -2^(EW-1) to 2^(EW-1)-1.
    - If mag < err_thr, the run counter increments (saturating at CONV_RUN); otherwise it resets to 0.
  - Exit priority (highest first), evaluated each cycle:
    - abort=1 -> HOLD, converged unchanged (0).
    - Run counter reaches CONV_RUN this cycle -> HOLD, converged:=1.
    - iter_cnt reaches MAX_ITER this cycle -> HOLD, converged:=0.
  - If convergence and MAX_ITER occur in the same cycle, convergence wins (converged=1).
  - The final update in the exit cycle is still applied (adapt_en stays 1 in that cycle).
- HOLD:
  - Single cycle: done=1, w_latch=1, adapt_en=0, busy=0, then -> IDLE.
- abort in INIT or FILL:
  - Goes to HOLD next cycle, clr_w deasserts immediately.
  - Weights are left at zero.
- start ignored when busy=1.
- start in HOLD is ignored; it must be re-issued in IDLE.
- err_thr=0: convergence is never declared.
- All outputs are registered (Moore) except adapt_en.
  - adapt_en is the delay-line output ANDed with a registered state==TRAIN flag.
  - It carries no combinational path from any input.
- iter_cnt holds its value in IDLE until the next start.
- rst_n asserted mid-run:
  - Returns to IDLE at once and all outputs go to 0.
  - No done pulse is issued.

Test Plan:
- Reset with snap_valid=1 and start=0 -> IDLE, all outputs 0 for 20 cycles, adapt_en never asserts.
- Convergence run: start, snap_valid=1 every cycle, err_thr=100, econj=(10,-20) -> clr_w high exactly cycles 1-2 after start. Then:
  - adapt_en first high on cycle 3+PIPE_LAT (cycle 7 at defaults).
  - done and w_latch pulse once when iter_cnt=16, with converged=1.
- Iteration limit: econj=(-131072,0), err_thr=200 -> no convergence; done when iter_cnt=1024, converged=0. Checks the saturated abs (131071), with no wrap to a small value.
- Sparse snapshots: snap_valid every 3rd cycle, threshold met -> each adapt_en lags its snap_valid by exactly PIPE_LAT cycles; converged after 16 adapted snapshots (about 48 cycles).
- Run reset: 15 good errors, 1 error with mag=err_thr, then good errors -> the run counter restarts; done arrives 16 samples after the bad sample, iter_cnt=32.
- Abort and reset mid-run:
  - abort during FILL -> HOLD next cycle, done=1, converged=0, iter_cnt=0.
  - rst_n low during TRAIN -> immediate IDLE with no done pulse; a second start begins cleanly with clr_w asserted again.
